// File: rtl/axis_arb_mux_pkg.sv
// Shared types and constants for the packet-level AXI-Stream arbiter/mux.
package axis_arb_mux_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StGranted
  } arb_state_e;

  localparam string ArbPriority   = "PRIORITY";
  localparam string ArbRoundRobin = "ROUND_ROBIN";
  localparam string LsbHigh       = "HIGH";
  localparam string LsbLow        = "LOW";

endpackage

// File: rtl/axis_arb_select.sv
// Combinational grant selection: fixed priority, or round-robin starting at ptr_i.
module axis_arb_select #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic            rr_i,
  input  logic            lsb_high_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  // Priority position <-> stream index; the mapping is its own inverse.
  function automatic int unsigned pos2idx(input int unsigned pos, input logic lsb_high);
    return lsb_high ? pos : (N - 1 - pos);
  endfunction

  always_comb begin
    int unsigned start;
    int unsigned pos;
    int unsigned idx;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    pos     = 0;
    idx     = 0;
    start   = rr_i ? pos2idx(int'(ptr_i), lsb_high_i) : 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = start + k;
      if (pos >= N) pos = pos - N;
      idx = pos2idx(pos, lsb_high_i);
      if (!valid_o && req_i[IdxW'(idx)]) begin
        valid_o              = 1'b1;
        idx_o                = IdxW'(idx);
        grant_o[IdxW'(idx)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_arb_mux.sv
// Packet-level AXI-Stream arbiter/mux with a registered grant and a 2-entry output skid.
module axis_arb_mux
  import axis_arb_mux_pkg::*;
#(
  parameter int unsigned S_COUNT      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter bit          USER_ENABLE  = 1'b1,
  parameter int unsigned USER_WIDTH   = 1,
  parameter string       ARB_TYPE     = "PRIORITY",
  parameter string       LSB_PRIORITY = "HIGH"
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [S_COUNT*DATA_WIDTH-1:0] input_tdata,
  input  logic [S_COUNT-1:0]            input_tvalid,
  output logic [S_COUNT-1:0]            input_tready,
  input  logic [S_COUNT-1:0]            input_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0] input_tuser,
  output logic [DATA_WIDTH-1:0]         output_tdata,
  output logic                          output_tvalid,
  input  logic                          output_tready,
  output logic                          output_tlast,
  output logic [USER_WIDTH-1:0]         output_tuser,
  output logic                          grant_valid,
  output logic [$clog2(S_COUNT)-1:0]    grant_index
);

  localparam int unsigned IdxW  = $clog2(S_COUNT);
  localparam bit          IsRr  = (ARB_TYPE == ArbRoundRobin);
  localparam bit          LsbHi = (LSB_PRIORITY != LsbLow);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(S_COUNT - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
  } beat_t;

  arb_state_e      state_q, state_d;
  logic            grant_valid_q, grant_valid_d;
  logic [IdxW-1:0] grant_idx_q, grant_idx_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;

  beat_t           mem_q [2];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      cnt_q, cnt_d;

  logic               stage_ready, accept, pop, last_hs, take;
  logic [S_COUNT-1:0] grant_oh, sel_req, sel_grant;
  logic [IdxW-1:0]    sel_idx;
  logic               sel_valid;
  beat_t              beat_in;

  assign stage_ready  = (cnt_q == 2'd0) || ((cnt_q == 2'd1) && output_tready);
  assign grant_oh     = {{(S_COUNT - 1){1'b0}}, 1'b1} << grant_idx_q;
  assign input_tready = (grant_valid_q && stage_ready) ? grant_oh : '0;
  assign accept       = grant_valid_q & stage_ready & input_tvalid[grant_idx_q];
  assign last_hs      = accept & input_tlast[grant_idx_q];
  assign pop          = (cnt_q != 2'd0) & output_tready;

  // The stream finishing its packet does not compete in the same-cycle re-arbitration.
  assign sel_req = (state_q == StGranted) ? (input_tvalid & ~grant_oh) : input_tvalid;

  axis_arb_select #(
    .N    (S_COUNT),
    .IdxW (IdxW)
  ) u_select (
    .req_i      (sel_req),
    .rr_i       (IsRr),
    .lsb_high_i (LsbHi),
    .ptr_i      (rr_ptr_q),
    .grant_o    (sel_grant),
    .idx_o      (sel_idx),
    .valid_o    (sel_valid)
  );

  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    rr_ptr_d      = rr_ptr_q;
    take          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sel_valid) take = 1'b1;
      end
      StGranted: begin
        if (last_hs) begin
          if (sel_valid) begin
            take = 1'b1;
          end else begin
            state_d       = StIdle;
            grant_valid_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (take) begin
      state_d       = StGranted;
      grant_valid_d = 1'b1;
      grant_idx_d   = sel_idx;
      if (LsbHi) rr_ptr_d = (sel_idx == LastIdx) ? '0 : sel_idx + 1'b1;
      else       rr_ptr_d = (sel_idx == '0) ? LastIdx : sel_idx - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      rr_ptr_q      <= LsbHi ? '0 : LastIdx;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  always_comb begin
    beat_in.data = input_tdata[grant_idx_q*DATA_WIDTH +: DATA_WIDTH];
    beat_in.last = input_tlast[grant_idx_q];
    beat_in.user = USER_ENABLE ? input_tuser[grant_idx_q*USER_WIDTH +: USER_WIDTH] : '0;
    cnt_d        = cnt_q + {1'b0, accept} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= beat_in;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

  assign output_tvalid = (cnt_q != 2'd0);
  assign output_tdata  = mem_q[rd_ptr_q].data;
  assign output_tlast  = mem_q[rd_ptr_q].last;
  assign output_tuser  = mem_q[rd_ptr_q].user;
  assign grant_valid   = grant_valid_q;
  assign grant_index   = grant_idx_q;

endmodule

// File: tb/tb_axis_arb_mux.sv
// Directed bench: priority instance and round-robin instance of axis_arb_mux.
module tb_axis_arb_mux;

  logic        clk;
  logic        rst_n;

  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready, in_last, in_user;
  logic [7:0]  o_data;
  logic        o_valid, o_ready, o_last, o_user, gv;
  logic [1:0]  gi;

  logic [31:0] r_data;
  logic [3:0]  r_valid, r_tready, r_last, r_user;
  logic [7:0]  ro_data;
  logic        ro_valid, ro_ready, ro_last, ro_user, rgv;
  logic [1:0]  rgi;

  int n_pass = 0;
  int n_tot  = 0;

  axis_arb_mux dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .input_tdata   (in_data),
    .input_tvalid  (in_valid),
    .input_tready  (in_ready),
    .input_tlast   (in_last),
    .input_tuser   (in_user),
    .output_tdata  (o_data),
    .output_tvalid (o_valid),
    .output_tready (o_ready),
    .output_tlast  (o_last),
    .output_tuser  (o_user),
    .grant_valid   (gv),
    .grant_index   (gi)
  );

  axis_arb_mux #(
    .ARB_TYPE ("ROUND_ROBIN")
  ) dut_rr (
    .clk           (clk),
    .rst_n         (rst_n),
    .input_tdata   (r_data),
    .input_tvalid  (r_valid),
    .input_tready  (r_tready),
    .input_tlast   (r_last),
    .input_tuser   (r_user),
    .output_tdata  (ro_data),
    .output_tvalid (ro_valid),
    .output_tready (ro_ready),
    .output_tlast  (ro_last),
    .output_tuser  (ro_user),
    .grant_valid   (rgv),
    .grant_index   (rgi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_beat(input string tag, input logic ov, input logic [7:0] od, input logic ol,
                          input logic ev, input logic [7:0] ed, input logic el);
    chk({tag, "_valid"}, 32'(ov), 32'(ev));
    chk({tag, "_data"},  32'(od), 32'(ed));
    chk({tag, "_last"},  32'(ol), 32'(el));
  endtask

  initial begin
    rst_n    = 1'b0;
    in_data  = '0;
    in_valid = '0;
    in_last  = '0;
    in_user  = '0;
    o_ready  = 1'b1;
    r_data   = '0;
    r_valid  = '0;
    r_last   = '0;
    r_user   = '0;
    ro_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_ovalid", 32'(o_valid), 32'd0);
    chk("rst_gv",     32'(gv),      32'd0);
    chk("rst_gi",     32'(gi),      32'd0);
    chk("rst_tready", 32'(in_ready), 32'd0);
    chk("rst_tdata",  32'(o_data),  32'd0);
    chk("rst_rr_gv",  32'(rgv),     32'd0);
    #5 rst_n = 1'b1;

    // A: priority, streams 0 and 2 each send 3 beats
    cyc();
    in_data[7:0]   = 8'h10;
    in_data[23:16] = 8'h30;
    in_user        = 4'b0001;
    in_valid       = 4'b0101;
    cyc();
    chk("a_gv",     32'(gv),       32'd1);
    chk("a_gi",     32'(gi),       32'd0);
    chk("a_tready", 32'(in_ready), 32'b0001);
    chk("a_ov0",    32'(o_valid),  32'd0);
    cyc();
    chk_beat("a_b0", o_valid, o_data, o_last, 1'b1, 8'h10, 1'b0);
    chk("a_user0", 32'(o_user), 32'd1);
    in_data[7:0] = 8'h11;
    cyc();
    chk_beat("a_b1", o_valid, o_data, o_last, 1'b1, 8'h11, 1'b0);
    in_data[7:0] = 8'h12;
    in_last[0]   = 1'b1;
    cyc();
    chk_beat("a_b2", o_valid, o_data, o_last, 1'b1, 8'h12, 1'b1);
    chk("a_gi2",     32'(gi),       32'd2);
    chk("a_tready2", 32'(in_ready), 32'b0100);
    in_valid[0] = 1'b0;
    in_last[0]  = 1'b0;
    cyc();
    chk_beat("a_c0", o_valid, o_data, o_last, 1'b1, 8'h30, 1'b0);
    chk("a_user2", 32'(o_user), 32'd0);
    in_data[23:16] = 8'h31;
    cyc();
    chk_beat("a_c1", o_valid, o_data, o_last, 1'b1, 8'h31, 1'b0);
    in_data[23:16] = 8'h32;
    in_last[2]     = 1'b1;
    cyc();
    chk_beat("a_c2", o_valid, o_data, o_last, 1'b1, 8'h32, 1'b1);
    chk("a_gv_end", 32'(gv), 32'd0);
    in_valid = '0;
    in_last  = '0;
    in_user  = '0;
    cyc();
    chk("a_idle", 32'(o_valid), 32'd0);

    // C: backpressure for 5 cycles mid-packet on stream 1
    in_data[15:8] = 8'h20;
    in_valid      = 4'b0010;
    cyc();
    chk("c_gi", 32'(gi), 32'd1);
    cyc();
    chk_beat("c_b0", o_valid, o_data, o_last, 1'b1, 8'h20, 1'b0);
    chk("c_tready", 32'(in_ready), 32'b0010);
    o_ready       = 1'b0;
    in_data[15:8] = 8'h21;
    #1;
    chk("c_tready_bp", 32'(in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_beat("c_hold", o_valid, o_data, o_last, 1'b1, 8'h20, 1'b0);
      chk("c_tready_hold", 32'(in_ready), 32'd0);
    end
    o_ready = 1'b1;
    #1;
    chk("c_tready_rel", 32'(in_ready), 32'b0010);
    cyc();
    chk_beat("c_b1", o_valid, o_data, o_last, 1'b1, 8'h21, 1'b0);
    in_data[15:8] = 8'h22;
    cyc();
    chk_beat("c_b2", o_valid, o_data, o_last, 1'b1, 8'h22, 1'b0);
    in_data[15:8] = 8'h23;
    in_last[1]    = 1'b1;
    cyc();
    chk_beat("c_b3", o_valid, o_data, o_last, 1'b1, 8'h23, 1'b1);
    chk("c_gv_end", 32'(gv), 32'd0);
    in_valid = '0;
    in_last  = '0;
    cyc();
    chk("c_idle", 32'(o_valid), 32'd0);

    // D: stream 1 stalls mid-packet while stream 0 requests; no preemption
    in_data[15:8] = 8'h40;
    in_valid      = 4'b0010;
    cyc();
    chk("d_gi", 32'(gi), 32'd1);
    cyc();
    chk_beat("d_b0", o_valid, o_data, o_last, 1'b1, 8'h40, 1'b0);
    in_valid     = 4'b0001;
    in_data[7:0] = 8'h50;
    in_last[0]   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("d_gv_hold",     32'(gv),       32'd1);
      chk("d_gi_hold",     32'(gi),       32'd1);
      chk("d_tready_hold", 32'(in_ready), 32'b0010);
      chk("d_ov_hold",     32'(o_valid),  32'd0);
    end
    in_valid      = 4'b0011;
    in_data[15:8] = 8'h41;
    in_last[1]    = 1'b1;
    cyc();
    chk_beat("d_b1", o_valid, o_data, o_last, 1'b1, 8'h41, 1'b1);
    chk("d_gi0",     32'(gi),       32'd0);
    chk("d_tready0", 32'(in_ready), 32'b0001);
    in_valid   = 4'b0001;
    in_last[1] = 1'b0;
    cyc();
    chk_beat("d_s0", o_valid, o_data, o_last, 1'b1, 8'h50, 1'b1);
    chk("d_gv_end", 32'(gv), 32'd0);
    in_valid = '0;
    in_last  = '0;
    cyc();
    chk("d_idle", 32'(o_valid), 32'd0);

    // B: round-robin, all four streams send continuous 1-beat packets
    r_data  = 32'h73727170;
    r_valid = 4'hf;
    r_last  = 4'hf;
    cyc();
    chk("b_gi1", 32'(rgi), 32'd0);
    chk("b_gv1", 32'(rgv), 32'd1);
    for (int i = 2; i <= 5; i++) begin
      cyc();
      chk("b_gi", 32'(rgi), 32'((i - 1) % 4));
      chk_beat("b_beat", ro_valid, ro_data, ro_last, 1'b1, 8'(8'h70 + i - 2), 1'b1);
      chk("b_user", 32'(ro_user), 32'd0);
      if (i == 3) chk("b_tready", 32'(r_tready), 32'b0100);
    end
    r_valid = '0;
    r_last  = '0;
    cyc();
    chk("b_drain", 32'(ro_valid), 32'd0);

    // E: reset during beat 2 of a 4-beat packet on stream 3
    in_data[31:24] = 8'h60;
    in_valid       = 4'b1000;
    cyc();
    chk("e_gi", 32'(gi), 32'd3);
    cyc();
    chk_beat("e_b0", o_valid, o_data, o_last, 1'b1, 8'h60, 1'b0);
    in_data[31:24] = 8'h61;
    cyc();
    chk_beat("e_b1", o_valid, o_data, o_last, 1'b1, 8'h61, 1'b0);
    in_data[31:24] = 8'h62;
    rst_n          = 1'b0;
    #1;
    chk("e_rst_ov",     32'(o_valid),  32'd0);
    chk("e_rst_gv",     32'(gv),       32'd0);
    chk("e_rst_tready", 32'(in_ready), 32'd0);
    chk("e_rst_tdata",  32'(o_data),   32'd0);
    chk("e_rst_rr_gv",  32'(rgv),      32'd0);
    in_valid = '0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("e_post_ov", 32'(o_valid), 32'd0);
    chk("e_post_gv", 32'(gv),      32'd0);
    cyc();
    chk("e_post_ov2", 32'(o_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
